div_seq: RTL and testbench
==========================

# div_seq

Iterative radix-2 divide sequencer serving the execution stage for RV32M DIV, DIVU, REM and REMU. It accepts one operation at a time from the execute stage and runs a restoring-division datapath one quotient bit per cycle. It handles the RISC-V divide-by-zero and signed-overflow cases on a fast path. While an operation is in flight it drives the stall that freezes the pipeline ahead of execute, and it returns the result with a single-cycle valid pulse.

## Interface
- XLEN, 32, operand and result width; iteration count equals XLEN.
- clk_i  input  1  core clock, rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- start_i  input  1  divide operation present in execute; held high while stalled.
- flush_i  input  1  abort current operation (branch mispredict or trap).
- op_i  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled at accept.
- dividend_i  input  XLEN  rs1 after forwarding; sampled at accept.
- divisor_i  input  XLEN  rs2 after forwarding; sampled at accept.
- stall_o  output  1  pipeline hold request (combinational).
- busy_o  output  1  state is not IDLE.
- valid_o  output  1  result_o valid this cycle (one-cycle pulse).
- result_o  output  XLEN  quotient or remainder per the latched op.

## Operation
- States: IDLE, CALC, DONE.
- Accept: in IDLE, when start_i=1 and flush_i=0. At accept, latch op, operand signs, |dividend| and |divisor|. Absolute values apply only for signed ops; unsigned ops use raw values.
- Accept transitions:
  - Divisor = 0 goes IDLE->DONE. Quotient = all ones. Remainder = dividend (raw, unsigned interpretation of its bits).
  - Signed op with dividend = 0x8000_0000 and divisor = 0xFFFF_FFFF goes IDLE->DONE. Quotient = 0x8000_0000. Remainder = 0.
  - Otherwise IDLE->CALC, iteration counter = 0, partial remainder = 0.
- CALC, each cycle:
  - Shift {rem, quo} left by 1, bringing in the dividend MSB.
  - Trial subtract: rem − |divisor|, computed XLEN+1 bits wide. If the result is non-negative, keep it and set quotient bit 0 to 1.
  - The counter increments. After the step with counter = XLEN−1, go to DONE.
- Sign fix, applied on entry to DONE:
  - Signed quotient is negated when the operand signs differ.
  - Signed remainder takes the sign of the dividend.
  - Result is two's complement, truncated to XLEN.
- DONE: valid_o=1, result_o driven from the result register. Next state is IDLE unconditionally. start_i still high in DONE is ignored and does not re-accept.
- result_o holds its last value after DONE until the next DONE; it is meaningful only while valid_o=1.
- flush_i=1 in any state: next state is IDLE, no valid_o pulse, counter cleared. A start_i in the same cycle as flush_i is not accepted.
- start_i while in CALC or DONE is not accepted.
- stall_o = (IDLE & start_i & !flush_i) | CALC. stall_o is 0 in DONE so execute advances on that edge.

## Timing
- Reset values: state IDLE, stall_o=0, busy_o=0, valid_o=0, result_o=0, counter=0.
- Normal op:
  - Accept at edge 0.
  - CALC occupies cycles 1..XLEN.
  - DONE/valid_o is in cycle XLEN+1 (cycle 33 for XLEN=32).
  - stall_o is high from the accept cycle through cycle XLEN.
- Fast path (zero divisor or overflow): accept cycle has stall_o=1; valid_o is high in the next cycle. Total latency is 1.
- Back-to-back: after DONE, the earliest next accept is the following cycle in IDLE.
- Reset asserted mid-operation forces the reset values immediately (asynchronous). No valid_o pulse occurs after release.
- busy_o is registered; stall_o is combinational from start_i, flush_i and the state.

## Test plan
- DIVU 100 / 7: valid_o in cycle 33, result 14. REMU with the same operands gives 2. stall_o is high for cycles 0..32.
- DIV −7 / 2: result 0xFFFF_FFFD (−3). REM −7 / 2: result 0xFFFF_FFFF (−1). DIV 7 / −2: result −3.
- DIV 5 / 0: valid_o in cycle 1, result 0xFFFF_FFFF. REM 5 / 0: result 5. stall_o is high only in cycle 0.
- DIV 0x8000_0000 / 0xFFFF_FFFF: result 0x8000_0000. REM with the same operands: result 0. DIVU with the same operands goes through CALC and gives result 0.
- flush_i at cycle 10 of CALC: IDLE next cycle, valid_o never pulses, stall_o drops. An immediate new DIVU 9 / 3 gives 3 with full latency.
- rst_ni pulled low during CALC: all outputs go to 0 at once. After release, start_i held high in IDLE is accepted as a fresh operation.

Source files
------------

// File: rtl/div_seq.sv
`default_nettype none
// ============================================================================
//  Module   : div_seq
//  Purpose  : Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//             Produces one quotient bit per cycle. Divide-by-zero and signed
//             overflow take a single-cycle fast path. Holds the pipeline with
//             stall_o while busy and returns the result with a one-cycle
//             valid pulse.
//  Revision : 1.0  initial release
// ============================================================================
module div_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        op_q, op_d;           // bit0: unsigned, bit1: remainder
    logic              sign_a_q, sign_a_d;   // dividend negative (signed ops only)
    logic              sign_b_q, sign_b_d;   // divisor negative (signed ops only)
    logic [XLEN-1:0]   rem_q, rem_d;         // partial remainder
    logic [XLEN-1:0]   quo_q, quo_d;         // dividend shifting out / quotient shifting in
    logic [XLEN-1:0]   dvsr_q, dvsr_d;       // |divisor|
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;

    // Accept-time decode
    logic              w_accept;
    logic              w_signed_in;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic              w_div_zero;
    logic              w_overflow;

    // Iteration datapath
    logic [XLEN:0]     w_shifted;
    logic [XLEN:0]     w_diff;
    logic              w_fits;
    logic [XLEN-1:0]   w_rem_next;
    logic [XLEN-1:0]   w_quo_next;
    logic [XLEN-1:0]   w_quo_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic [XLEN-1:0]   w_final;

    // Operand decode at the accept point: magnitudes only for signed ops
    always_comb begin
        w_accept    = (state_q == S_IDLE) && start_i && !flush_i;
        w_signed_in = !op_i[0];
        w_a_neg     = w_signed_in && dividend_i[XLEN-1];
        w_b_neg     = w_signed_in && divisor_i[XLEN-1];
        w_abs_a     = w_a_neg ? (~dividend_i + XLEN'(1)) : dividend_i;
        w_abs_b     = w_b_neg ? (~divisor_i + XLEN'(1)) : divisor_i;
        w_div_zero  = (divisor_i == '0);
        w_overflow  = w_signed_in
                      && (dividend_i == {1'b1, {(XLEN-1){1'b0}}})
                      && (divisor_i == '1);
    end

    // One restoring step plus the sign fix applied when the last step lands.
    // The trial difference is XLEN+1 wide; its MSB is the sign because the
    // shifted remainder is always below twice the divisor.
    always_comb begin
        w_shifted  = {rem_q, quo_q[XLEN-1]};
        w_diff     = w_shifted - {1'b0, dvsr_q};
        w_fits     = !w_diff[XLEN];
        w_rem_next = w_fits ? w_diff[XLEN-1:0] : w_shifted[XLEN-1:0];
        w_quo_next = {quo_q[XLEN-2:0], w_fits};
        w_quo_fix  = (!op_q[0] && (sign_a_q ^ sign_b_q)) ? (~w_quo_next + XLEN'(1)) : w_quo_next;
        w_rem_fix  = (!op_q[0] && sign_a_q) ? (~w_rem_next + XLEN'(1)) : w_rem_next;
        w_final    = op_q[1] ? w_rem_fix : w_quo_fix;
    end

    // Next-state and datapath update; flush overrides everything
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        if (flush_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (w_accept) begin
                        op_d     = op_i;
                        sign_a_d = w_a_neg;
                        sign_b_d = w_b_neg;
                        quo_d    = w_abs_a;
                        dvsr_d   = w_abs_b;
                        rem_d    = '0;
                        cnt_d    = '0;
                        if (w_div_zero) begin
                            // Quotient all ones, remainder is the raw dividend
                            result_d = op_i[1] ? dividend_i : '1;
                            state_d  = S_DONE;
                        end else if (w_overflow) begin
                            // Quotient is the most-negative value, remainder zero
                            result_d = op_i[1] ? '0 : dividend_i;
                            state_d  = S_DONE;
                        end else begin
                            state_d  = S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    rem_d = w_rem_next;
                    quo_d = w_quo_next;
                    if (cnt_q == C_LAST) begin
                        cnt_d    = '0;
                        result_d = w_final;
                        state_d  = S_DONE;
                    end else begin
                        cnt_d    = cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and result registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // Outputs; stall is gated by reset so it reads 0 while reset is held
    always_comb begin
        stall_o  = (rst_ni && w_accept) || (state_q == S_CALC);
        busy_o   = (state_q != S_IDLE);
        valid_o  = (state_q == S_DONE);
        result_o = result_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_div_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div_seq
//  Purpose  : Directed self-checking bench for div_seq.
//  Revision : 1.0  initial release
// ============================================================================
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        stall;
    logic        busy;
    logic        valid;
    logic [31:0] result;

    int checks   = 0;
    int failures = 0;

    localparam logic [1:0] C_DIV  = 2'b00;
    localparam logic [1:0] C_DIVU = 2'b01;
    localparam logic [1:0] C_REM  = 2'b10;
    localparam logic [1:0] C_REMU = 2'b11;

    div_seq #(.XLEN(32)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .flush_i    (flush),
        .op_i       (op),
        .dividend_i (a),
        .divisor_i  (b),
        .stall_o    (stall),
        .busy_o     (busy),
        .valid_o    (valid),
        .result_o   (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Present an operation just after a rising edge; that cycle is cycle 0
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(posedge clk);
        #1;
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
    endtask

    // Follow an issued operation through to its valid pulse and the idle cycle after
    task automatic collect(input logic [31:0] exp_res, input int exp_lat, input string tag);
        int          lat;
        int          stall_bad;
        logic [31:0] res;
        lat       = -1;
        stall_bad = 0;
        res       = '0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                lat = n;
                res = result;
                if (stall !== 1'b0) stall_bad++;
                break;
            end
            if (stall !== 1'b1) stall_bad++;
        end
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " result"}, res, exp_res);
        chk({tag, " stall_profile"}, stall_bad, 0);
        @(posedge clk);
        #1;
        chk({tag, " idle_after_done"}, {31'd0, busy}, 32'd0);
        chk({tag, " single_pulse"}, {31'd0, valid}, 32'd0);
        start = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp_res, input int exp_lat, input string tag);
        issue(o, x, y);
        collect(exp_res, exp_lat, tag);
    endtask

    initial begin
        int valid_seen;

        // Reset state
        #12;
        chk("reset stall", {31'd0, stall}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset valid", {31'd0, valid}, 32'd0);
        chk("reset result", result, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Unsigned and signed normal division
        run_op(C_DIVU, 32'd100, 32'd7, 32'd14, 33, "divu_100_7");
        run_op(C_REMU, 32'd100, 32'd7, 32'd2, 33, "remu_100_7");
        run_op(C_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div_m7_2");
        run_op(C_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem_m7_2");
        run_op(C_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, "div_7_m2");
        run_op(C_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, "rem_7_m2");

        // Divide by zero fast path
        run_op(C_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "div_5_0");
        run_op(C_REM, 32'd5, 32'd0, 32'd5, 1, "rem_5_0");
        run_op(C_REMU, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1, "remu_m7_0");

        // Signed overflow fast path; unsigned goes through the iteration
        run_op(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
        run_op(C_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf");
        run_op(C_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, "divu_ovf_operands");

        // start together with flush is not accepted
        @(posedge clk);
        #1;
        op = C_DIVU; a = 32'd50; b = 32'd5; start = 1'b1; flush = 1'b1;
        #1;
        chk("start_with_flush stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        chk("start_with_flush busy", {31'd0, busy}, 32'd0);
        start = 1'b0; flush = 1'b0;

        // Flush in the middle of CALC
        issue(C_DIVU, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        #1;
        chk("flush calc_stall", {31'd0, stall}, 32'd1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        start = 1'b0;
        chk("flush busy", {31'd0, busy}, 32'd0);
        chk("flush stall", {31'd0, stall}, 32'd0);
        valid_seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (valid !== 1'b0) valid_seen++;
        end
        chk("flush no_valid", valid_seen, 0);
        run_op(C_DIVU, 32'd9, 32'd3, 32'd3, 33, "divu_9_3_after_flush");

        // Asynchronous reset during CALC, start held high through and after
        issue(C_DIV, 32'hFFFF_FFF9, 32'd2);
        repeat (15) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst stall", {31'd0, stall}, 32'd0);
        chk("async_rst busy", {31'd0, busy}, 32'd0);
        chk("async_rst valid", {31'd0, valid}, 32'd0);
        chk("async_rst result", result, 32'd0);
        valid_seen = 0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (valid !== 1'b0) valid_seen++;
        end
        chk("async_rst no_valid", valid_seen, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        collect(32'hFFFF_FFFD, 33, "restart_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
